// File: rtl/icache_fill_ctrl_if.sv
// Memory-side bus of the instruction cache: read request out, line response in.
// The cache is the master; the unified memory serves the slave side.
interface icache_fill_ctrl_if;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;    // 0 = read, 1 = idle (never a write)
    } mem_req_type;

    typedef struct packed {
        logic [63:0] data;
        logic        ready;
    } mem_data_type;

    mem_req_type  mem_req;
    mem_data_type mem_data_res;

    modport master (output mem_req, input mem_data_res);
    modport slave  (input mem_req, output mem_data_res);

endinterface

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a single-line miss/fill controller.
// Hits return in the same cycle; a miss stalls IF and fetches one full line.
module icache_fill_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int MISS_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           pc,
    input  logic                  pc_valid,
    input  logic                  flush,
    output logic [15:0]           instr,
    output logic                  instr_valid,
    output logic                  stall,
    icache_fill_ctrl_if.master    mem,
    output logic [MISS_CNT_W-1:0] miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 14 - INDEX_W;
    localparam int LINE_W  = 16 * LINE_WORDS;

    typedef enum logic {
        COMPARE = 1'b0,
        WAIT    = 1'b1
    } state_t;

    state_t                  state_r;
    logic [NUM_LINES-1:0]    valid_r;
    logic [TAG_W-1:0]        tag_r  [NUM_LINES];
    logic [LINE_W-1:0]       data_r [NUM_LINES];
    logic [13:0]             miss_line_r;
    logic                    rw_r;
    logic [MISS_CNT_W-1:0]   miss_count_r;

    logic [INDEX_W-1:0]      index_s;
    logic [TAG_W-1:0]        tag_s;
    logic [1:0]              offset_s;
    logic [INDEX_W-1:0]      fill_index_s;
    logic [TAG_W-1:0]        fill_tag_s;
    logic                    hit_s;
    logic                    fill_s;
    logic [LINE_W-1:0]       line_s;

    function automatic logic [15:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] off);
        return line[{off, 4'b0000} +: 16];
    endfunction

    assign offset_s     = pc[1:0];
    assign index_s      = pc[2 +: INDEX_W];
    assign tag_s        = pc[15:2+INDEX_W];
    assign fill_index_s = miss_line_r[INDEX_W-1:0];
    assign fill_tag_s   = miss_line_r[13:INDEX_W];
    assign line_s       = data_r[index_s];

    // Flush deliberately does not take part in the compare of its own cycle.
    assign hit_s  = pc_valid & valid_r[index_s] & (tag_r[index_s] == tag_s);
    assign fill_s = (state_r == WAIT) & mem.mem_data_res.ready;

    assign mem.mem_req = {miss_line_r, 2'b00, 16'h0000, rw_r};
    assign miss_count  = miss_count_r;

    // Fetch-side outputs: zero-latency hit path, forced quiet while in reset.
    always_comb begin
        instr       = 16'h0000;
        instr_valid = 1'b0;
        stall       = 1'b0;
        if (!rst_n) begin
            instr       = 16'h0000;
            instr_valid = 1'b0;
            stall       = 1'b0;
        end else begin
            case (state_r)
                COMPARE: begin
                    if (hit_s) begin
                        instr       = word_sel(line_s, offset_s);
                        instr_valid = 1'b1;
                    end else begin
                        instr       = 16'h0000;
                        instr_valid = 1'b0;
                    end
                    stall = pc_valid & ~hit_s;
                end
                WAIT: begin
                    stall = pc_valid;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    // Miss/fill FSM with registered request fields and saturating miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= COMPARE;
            rw_r         <= 1'b1;
            miss_line_r  <= 14'h0000;
            miss_count_r <= {MISS_CNT_W{1'b0}};
        end else begin
            case (state_r)
                COMPARE: begin
                    if (pc_valid && !hit_s) begin
                        state_r     <= WAIT;
                        rw_r        <= 1'b0;
                        miss_line_r <= pc[15:2];
                        if (miss_count_r != {MISS_CNT_W{1'b1}}) begin
                            miss_count_r <= miss_count_r + MISS_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_data_res.ready) begin
                        state_r <= COMPARE;
                        rw_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= COMPARE;
                    rw_r    <= 1'b1;
                end
            endcase
        end
    end

    // Valid bits: flush beats a coincident fill, leaving the written line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (flush) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (fill_s) begin
            valid_r[fill_index_s] <= 1'b1;
        end
    end

    // Tag and data arrays are plain storage without reset.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[fill_index_s]  <= fill_tag_s;
            data_r[fill_index_s] <= mem.mem_data_res.data[LINE_W-1:0];
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: hits, misses, conflicts, flush, reset and
// counter saturation (a second instance with a 2-bit miss counter shares the stimulus).
module tb_icache_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [15:0] instr, instr2;
    logic        instr_valid, instr_valid2;
    logic        stall, stall2;
    logic [15:0] miss_count;
    logic [1:0]  miss_count2;

    int n_cmp;
    int n_err;

    icache_fill_ctrl_if mif ();
    icache_fill_ctrl_if mif2 ();

    assign mif2.mem_data_res = mif.mem_data_res;

    icache_fill_ctrl #(.NUM_LINES(16), .LINE_WORDS(4), .MISS_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .mem(mif), .miss_count(miss_count)
    );

    icache_fill_ctrl #(.NUM_LINES(16), .LINE_WORDS(4), .MISS_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .instr(instr2), .instr_valid(instr_valid2), .stall(stall2),
        .mem(mif2), .miss_count(miss_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss on pc, serve the line after a 4-cycle memory latency, check the resulting hit.
    task automatic miss_fill(input string tag, input logic [15:0] a, input logic [15:0] exp_addr,
                             input logic [63:0] line, input logic [15:0] exp_instr,
                             input logic [15:0] exp_cnt);
        pc       = a;
        pc_valid = 1'b1;
        #1;
        check_val({tag, "_stall"}, {63'd0, stall}, 64'd1);
        check_val({tag, "_ivalid_miss"}, {63'd0, instr_valid}, 64'd0);
        tick();
        check_val({tag, "_rw_read"}, {63'd0, mif.mem_req.rw}, 64'd0);
        check_val({tag, "_addr"}, {48'd0, mif.mem_req.addr}, {48'd0, exp_addr});
        check_val({tag, "_wdata"}, {48'd0, mif.mem_req.data}, 64'd0);
        check_val({tag, "_count"}, {48'd0, miss_count}, {48'd0, exp_cnt});
        repeat (3) tick();
        check_val({tag, "_rw_hold"}, {63'd0, mif.mem_req.rw}, 64'd0);
        check_val({tag, "_stall_wait"}, {63'd0, stall}, 64'd1);
        mif.mem_data_res.data  = line;
        mif.mem_data_res.ready = 1'b1;
        tick();
        mif.mem_data_res.ready = 1'b0;
        #1;
        check_val({tag, "_instr"}, {48'd0, instr}, {48'd0, exp_instr});
        check_val({tag, "_ivalid"}, {63'd0, instr_valid}, 64'd1);
        check_val({tag, "_nostall"}, {63'd0, stall}, 64'd0);
        check_val({tag, "_rw_idle"}, {63'd0, mif.mem_req.rw}, 64'd1);
    endtask

    initial begin
        logic [15:0] exp_words [4];
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        pc       = 16'h0000;
        pc_valid = 1'b1;
        flush    = 1'b0;
        mif.mem_data_res = '0;
        #2 rst_n = 1'b0;
        repeat (2) tick();

        // Reset state, with a pending fetch that must not raise stall.
        check_val("rst_rw", {63'd0, mif.mem_req.rw}, 64'd1);
        check_val("rst_addr", {48'd0, mif.mem_req.addr}, 64'd0);
        check_val("rst_count", {48'd0, miss_count}, 64'd0);
        check_val("rst_stall", {63'd0, stall}, 64'd0);
        check_val("rst_ivalid", {63'd0, instr_valid}, 64'd0);
        check_val("rst_instr", {48'd0, instr}, 64'd0);
        pc_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // 1: cold miss.
        miss_fill("cold", 16'h0041, 16'h0040, 64'h4444_3333_2222_1111, 16'h2222, 16'd1);
        check_val("cold_sat_count", {62'd0, miss_count2}, 64'd1);

        // 2: back-to-back hits on the same line.
        exp_words[0] = 16'h1111;
        exp_words[1] = 16'h2222;
        exp_words[2] = 16'h3333;
        exp_words[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            tick();
            pc = 16'h0040 + 16'(i);
            #1;
            check_val("hit_instr", {48'd0, instr}, {48'd0, exp_words[i]});
            check_val("hit_nostall", {63'd0, stall}, 64'd0);
            check_val("hit_rw", {63'd0, mif.mem_req.rw}, 64'd1);
        end
        tick();
        check_val("hit_count", {48'd0, miss_count}, 64'd1);

        // 3: conflict on index 0, then the evicted line misses again.
        miss_fill("conf_a", 16'h0440, 16'h0440, 64'h8888_7777_6666_5555, 16'h5555, 16'd2);
        tick();
        miss_fill("conf_b", 16'h0040, 16'h0040, 64'h4444_3333_2222_1111, 16'h1111, 16'd3);
        check_val("conf_sat_count", {62'd0, miss_count2}, 64'd3);
        tick();

        // 4: flush coincident with ready leaves the line invalid.
        pc       = 16'h0084;
        pc_valid = 1'b1;
        #1;
        check_val("fl_stall", {63'd0, stall}, 64'd1);
        tick();
        check_val("fl_rw", {63'd0, mif.mem_req.rw}, 64'd0);
        repeat (3) tick();
        mif.mem_data_res.data  = 64'hAAAA_BBBB_CCCC_DDDD;
        mif.mem_data_res.ready = 1'b1;
        flush = 1'b1;
        tick();
        mif.mem_data_res.ready = 1'b0;
        flush = 1'b0;
        #1;
        check_val("fl_ivalid", {63'd0, instr_valid}, 64'd0);
        check_val("fl_remiss", {63'd0, stall}, 64'd1);
        check_val("fl_rw_idle", {63'd0, mif.mem_req.rw}, 64'd1);
        tick();
        check_val("fl_rereq_rw", {63'd0, mif.mem_req.rw}, 64'd0);
        check_val("fl_rereq_addr", {48'd0, mif.mem_req.addr}, 64'h0084);
        check_val("fl_count", {48'd0, miss_count}, 64'd5);
        repeat (3) tick();
        mif.mem_data_res.ready = 1'b1;
        tick();
        mif.mem_data_res.ready = 1'b0;
        #1;
        check_val("fl_instr", {48'd0, instr}, 64'hDDDD);
        check_val("fl_ivalid2", {63'd0, instr_valid}, 64'd1);
        check_val("fl_sat_count", {62'd0, miss_count2}, 64'd3);
        tick();

        // 5: reset in the middle of a fill; a late ready is ignored.
        pc = 16'h0048;
        #1;
        check_val("rw5_stall", {63'd0, stall}, 64'd1);
        tick();
        check_val("rw5_rw", {63'd0, mif.mem_req.rw}, 64'd0);
        rst_n = 1'b0;
        #1;
        check_val("rw5_rst_rw", {63'd0, mif.mem_req.rw}, 64'd1);
        check_val("rw5_rst_addr", {48'd0, mif.mem_req.addr}, 64'd0);
        check_val("rw5_rst_count", {48'd0, miss_count}, 64'd0);
        check_val("rw5_rst_stall", {63'd0, stall}, 64'd0);
        repeat (2) tick();
        rst_n    = 1'b1;
        pc_valid = 1'b0;
        mif.mem_data_res.data  = 64'h1234_1234_1234_1234;
        mif.mem_data_res.ready = 1'b1;
        tick();
        mif.mem_data_res.ready = 1'b0;
        check_val("rw5_stray_rw", {63'd0, mif.mem_req.rw}, 64'd1);
        miss_fill("rw5_refetch", 16'h0048, 16'h0048, 64'h0D0D_0C0C_0B0B_0A0A, 16'h0A0A, 16'd1);
        tick();

        // 6: five misses since reset saturate the 2-bit counter.
        miss_fill("sat1", 16'h004D, 16'h004C, 64'h1003_1002_1001_1000, 16'h1001, 16'd2);
        tick();
        miss_fill("sat2", 16'h0052, 16'h0050, 64'h2003_2002_2001_2000, 16'h2002, 16'd3);
        tick();
        miss_fill("sat3", 16'h0057, 16'h0054, 64'h3003_3002_3001_3000, 16'h3003, 16'd4);
        tick();
        miss_fill("sat4", 16'h0058, 16'h0058, 64'h4003_4002_4001_4000, 16'h4000, 16'd5);
        check_val("sat_count2", {62'd0, miss_count2}, 64'd3);
        check_val("sat_count16", {48'd0, miss_count}, 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
